// File: rtl/keypad_entry_ctrl.sv
// Keypad entry sequencer: buffers up to two BCD digits and commits them to the
// capture register as load_d -> load_u -> rdy. Partial entries are dropped on CLEAR or timeout.
//
//  state    | meaning
//  ---------|---------------------------------------------------------
//  S_IDLE   | no digits buffered
//  S_ONE    | one digit buffered in d1, idle timer running
//  S_TWO    | two digits buffered (d1 = tens, d2 = units), timer running
//  S_WR_D   | load_d + tens on tecla_d being presented
//  S_WR_U   | load_u + units on tecla_d being presented
//  S_COMMIT | rdy being presented; return to S_IDLE next
module keypad_entry_ctrl #(
  parameter logic [3:0]  KEY_ENTER   = 4'hF,
  parameter logic [3:0]  KEY_CLEAR   = 4'hE,
  parameter int unsigned TIMEOUT_CYC = 27_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] tecla_d,
  output logic       load_d,
  output logic       load_u,
  output logic       rdy,
  output logic       busy,
  output logic [1:0] n_digits,
  output logic       err,
  output logic       timeout
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ONE, S_TWO, S_WR_D, S_WR_U, S_COMMIT
  } state_t;

  state_t           state;
  logic [3:0]       d1, d2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      d1       <= '0;
      d2       <= '0;
      cnt      <= '0;
      tecla_d  <= '0;
      load_d   <= 1'b0;
      load_u   <= 1'b0;
      rdy      <= 1'b0;
      busy     <= 1'b0;
      n_digits <= '0;
      err      <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      tecla_d <= '0;
      load_d  <= 1'b0;
      load_u  <= 1'b0;
      rdy     <= 1'b0;
      err     <= 1'b0;
      timeout <= 1'b0;
      case (state)
        S_WR_D: begin
          err     <= key_valid;
          state   <= S_WR_U;
          load_u  <= 1'b1;
          tecla_d <= d2;
        end
        S_WR_U: begin
          err   <= key_valid;
          state <= S_COMMIT;
          rdy   <= 1'b1;
        end
        S_COMMIT: begin
          err      <= key_valid;
          state    <= S_IDLE;
          busy     <= 1'b0;
          n_digits <= 2'd0;
          d1       <= '0;
          d2       <= '0;
        end
        default: begin
          if (key_valid) begin
            // any keypress restarts the idle window, accepted or not
            cnt <= (state == S_IDLE) ? '0 : CNT_LOAD;
            if (key_code <= 4'd9) begin
              if (state == S_IDLE) begin
                d1       <= key_code;
                state    <= S_ONE;
                n_digits <= 2'd1;
                cnt      <= CNT_LOAD;
              end else if (state == S_ONE) begin
                d2       <= key_code;
                state    <= S_TWO;
                n_digits <= 2'd2;
              end else begin
                err <= 1'b1;
              end
            end else if (key_code == KEY_ENTER) begin
              if (state == S_IDLE) begin
                err <= 1'b1;
              end else begin
                state    <= S_WR_D;
                busy     <= 1'b1;
                load_d   <= 1'b1;
                n_digits <= 2'd2;
                cnt      <= '0;
                if (state == S_ONE) begin
                  // single digit becomes units with a zero tens
                  d1      <= '0;
                  d2      <= d1;
                  tecla_d <= '0;
                end else begin
                  tecla_d <= d1;
                end
              end
            end else if (key_code == KEY_CLEAR) begin
              state    <= S_IDLE;
              d1       <= '0;
              d2       <= '0;
              n_digits <= 2'd0;
              cnt      <= '0;
            end else begin
              err <= 1'b1;
            end
          end else if (state != S_IDLE) begin
            if (cnt == '0) begin
              state    <= S_IDLE;
              d1       <= '0;
              d2       <= '0;
              n_digits <= 2'd0;
              timeout  <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: directed scenarios plus random key traffic, checked
// every cycle against a queue-based reference model of the entry rules.
module tb_keypad_entry_ctrl;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = '0;
  logic [3:0] tecla_d;
  logic       load_d, load_u, rdy, busy, err, timeout;
  logic [1:0] n_digits;

  keypad_entry_ctrl #(
    .KEY_ENTER(4'hF), .KEY_CLEAR(4'hE), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .tecla_d(tecla_d), .load_d(load_d), .load_u(load_u), .rdy(rdy),
    .busy(busy), .n_digits(n_digits), .err(err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference model state
  int q[$];
  int phase = 0;
  int idle = 0;
  int m_t = 0, m_u = 0;
  logic [5:0] e_flags;
  logic [3:0] e_tecla;
  logic [1:0] e_n;
  logic [7:0] e_pack;

  // capture register built from the DUT strobes
  logic [3:0] cap_t = '0, cap_u = '0;
  logic [7:0] last_pack = '0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit kv, input logic [3:0] kc);
    logic ld, lu, rd, er, to;
    ld = 0; lu = 0; rd = 0; er = 0; to = 0;
    e_tecla = '0;
    if (r) begin
      q.delete(); phase = 0; idle = 0;
    end else if (phase != 0) begin
      er = kv;
      if (phase == 1) begin lu = 1; e_tecla = 4'(m_u); phase = 2; end
      else if (phase == 2) begin rd = 1; phase = 3; end
      else begin phase = 0; q.delete(); end
    end else if (kv) begin
      idle = 0;
      if (kc < 10) begin
        if (q.size() < 2) q.push_back(int'(kc)); else er = 1;
      end else if (kc == 4'hF) begin
        if (q.size() == 0) er = 1;
        else begin
          m_t = (q.size() == 2) ? q[0] : 0;
          m_u = q[q.size()-1];
          e_pack = 8'(m_t * 16 + m_u);
          phase = 1; ld = 1; e_tecla = 4'(m_t);
        end
      end else if (kc == 4'hE) begin
        q.delete();
      end else begin
        er = 1;
      end
    end else if (q.size() != 0) begin
      idle++;
      if (idle == TO) begin q.delete(); idle = 0; to = 1; end
    end
    e_n = (phase != 0) ? 2'd2 : 2'(q.size());
    e_flags = {ld, lu, rd, (phase != 0), er, to};
  endtask

  task automatic cyc(input bit r, input bit kv, input logic [3:0] kc);
    rst = r; key_valid = kv; key_code = kc;
    @(posedge clk);
    model(r, kv, kc);
    #1;
    chk("flags{ld,lu,rdy,busy,err,to}", {2'b00, load_d, load_u, rdy, busy, err, timeout}, {2'b00, e_flags});
    chk("tecla_d", {4'h0, tecla_d}, {4'h0, e_tecla});
    chk("n_digits", {6'h0, n_digits}, {6'h0, e_n});
    if (e_flags[3]) chk("packed_reg", {cap_t, cap_u}, e_pack);
    if (load_d) cap_t = tecla_d;
    if (load_u) cap_u = tecla_d;
    if (rdy) last_pack = {cap_t, cap_u};
  endtask

  task automatic key(input logic [3:0] kc);
    cyc(1'b0, 1'b1, kc);
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'h0);
  endtask

  initial begin
    int r;
    cyc(1'b1, 1'b0, 4'h0);
    cyc(1'b1, 1'b0, 4'h0);

    // 1: two-digit commit
    key(4'd4); key(4'd7); key(4'hF); wait_n(4);
    chk("pack_47", last_pack, 8'h47);

    // 2: single digit commit
    key(4'd5); key(4'hF); wait_n(4);
    chk("pack_05", last_pack, 8'h05);

    // 3: third digit rejected
    key(4'd1); key(4'd2); key(4'd3); key(4'hF); wait_n(4);
    chk("pack_12", last_pack, 8'h12);

    // 4: timeout then ENTER rejected
    key(4'd9); wait_n(TO + 2); key(4'hF); wait_n(2);
    // boundary: key on the would-be expiry cycle keeps the entry
    key(4'd2); wait_n(TO - 1); key(4'd8); wait_n(TO - 1); key(4'hF); wait_n(4);
    chk("pack_28", last_pack, 8'h28);

    // 5: clear, ENTER rejected, key during busy
    key(4'd3); key(4'hE); key(4'hF); key(4'd6); key(4'hF); key(4'd6); key(4'hB); wait_n(3);
    chk("pack_06", last_pack, 8'h06);
    key(4'hC); key(4'hA); key(4'hD);

    // 6: reset during commit
    last_pack = 8'hAA;
    key(4'd8); key(4'hF); wait_n(1); cyc(1'b1, 1'b0, 4'h0); wait_n(4);
    chk("no_rdy_after_rst", last_pack, 8'hAA);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) cyc(1'b1, 1'b0, 4'h0);
      else if ($urandom_range(0, 99) == 0) wait_n(TO + $urandom_range(0, 2) - 1);
      else if ($urandom_range(0, 9) < 5) begin
        r = $urandom_range(0, 9);
        if (r < 6) key(4'($urandom_range(0, 9)));
        else if (r < 8) key(4'hF);
        else if (r == 8) key(4'hE);
        else key(4'($urandom_range(0, 15)));
      end else cyc(1'b0, 1'b0, 4'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
